// File: rtl/audio_mem_pkg.sv
// Shared types for the audio sample write path: write FSM states, byte-enable
// patterns and the word entry carried through the FIFO.
package audio_mem_pkg;

    typedef enum logic {IDLE, BUS} wr_state_t;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_LOW  = 4'b0011;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } word_entry_t;

endpackage

// File: rtl/sample_word_fifo.sv
// Synchronous word FIFO between the sample packer and the Avalon write FSM.
// Exposes the entry behind the head so the writer can issue back-to-back writes.
module sample_word_fifo
    import audio_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  word_entry_t din,
    output word_entry_t dout,
    output word_entry_t dout_next,
    output logic        has_next,
    output logic        full,
    output logic        empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    word_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [PTR_W:0]   count;

    assign rd_nxt    = rd_ptr + PTR_W'(1);
    assign dout      = mem[rd_ptr];
    assign dout_next = mem[rd_nxt];
    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign has_next  = (count > (PTR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_writer.sv
// Avalon-MM write master: packs 16-bit samples in pairs, queues the words and
// writes them to a circular buffer of consecutive word addresses.
module audio_sample_writer
    import audio_mem_pkg::*;
#(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                NUM_WORDS  = 1024,
    parameter int                FIFO_DEPTH = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              sample_valid,
    input  logic [15:0]       sample,
    output logic              sample_ready,
    input  logic              waitrequest,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    output logic              wrapped,
    output logic [31:0]       words_written,
    output logic              idle
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(NUM_WORDS - 1);

    wr_state_t   state;
    word_entry_t push_entry, fifo_head, fifo_next;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_has_next;
    logic        fifo_empty_nx;
    logic [15:0] lo, lo_nx;
    logic        half_pending, half_nx, flush_pending, flush_nx;
    logic        accept, flush_req;

    sample_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       (push_entry),
        .dout      (fifo_head),
        .dout_next (fifo_next),
        .has_next  (fifo_has_next),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sample_ready = enable && !fifo_full;
    assign accept       = sample_valid && sample_ready;
    assign flush_req    = flush || flush_pending;
    assign fifo_pop     = (state == BUS) && !waitrequest;

    // Packer: an accepted sample takes precedence over a flush on the same edge.
    always_comb begin
        fifo_push  = 1'b0;
        push_entry = '0;
        lo_nx      = lo;
        half_nx    = half_pending;
        flush_nx   = flush_pending;
        if (accept) begin
            if (half_pending) begin
                fifo_push       = 1'b1;
                push_entry.data = {sample, lo};
                push_entry.be   = BE_FULL;
                half_nx         = 1'b0;
                flush_nx        = 1'b0;
            end else begin
                lo_nx    = sample;
                half_nx  = 1'b1;
                flush_nx = flush_req;
            end
        end else if (flush_req) begin
            if (!half_pending) begin
                flush_nx = 1'b0;
            end else if (!fifo_full) begin
                fifo_push       = 1'b1;
                push_entry.data = {16'h0, lo};
                push_entry.be   = BE_LOW;
                half_nx         = 1'b0;
                flush_nx        = 1'b0;
            end else begin
                flush_nx = 1'b1;
            end
        end
    end

    // A high write always implies a non-empty FIFO, so idle needs no write term.
    assign fifo_empty_nx = !fifo_push && (fifo_empty || (fifo_pop && !fifo_has_next));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            write         <= 1'b0;
            writedata     <= '0;
            byteenable    <= '0;
            address       <= BASE_ADDR;
            wrapped       <= 1'b0;
            words_written <= '0;
            idle          <= 1'b1;
            lo            <= '0;
            half_pending  <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            lo            <= lo_nx;
            half_pending  <= half_nx;
            flush_pending <= flush_nx;
            idle          <= fifo_empty_nx && !half_nx && !flush_nx;
            wrapped       <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        writedata  <= fifo_head.data;
                        byteenable <= fifo_head.be;
                        write      <= 1'b1;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        words_written <= words_written + 32'd1;
                        if (address == LAST_ADDR) begin
                            address <= BASE_ADDR;
                            wrapped <= 1'b1;
                        end else begin
                            address <= address + ADDR_W'(1);
                        end
                        if (fifo_has_next) begin
                            writedata  <= fifo_next.data;
                            byteenable <= fifo_next.be;
                        end else begin
                            write <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_writer.sv
// Bench for audio_sample_writer: directed scenarios plus random traffic checked
// against a word-queue reference model of the packer and circular writer.
module tb_audio_sample_writer;
    localparam int          ADDR_W = 23;
    localparam logic [22:0] BASE   = 23'h100;
    localparam int          NW     = 4;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset, enable, flush, sample_valid, waitrequest;
    logic [15:0] sample;
    logic        sample_ready, write, wrapped, idle;
    logic [22:0] address;
    logic [31:0] writedata, words_written;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    audio_sample_writer #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NUM_WORDS(NW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .sample_valid(sample_valid), .sample(sample), .sample_ready(sample_ready),
        .waitrequest(waitrequest), .address(address), .write(write),
        .writedata(writedata), .byteenable(byteenable), .wrapped(wrapped),
        .words_written(words_written), .idle(idle)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: words queued for memory ({data, be}) plus packer flags.
    logic [35:0] exp_q[$];
    logic        m_half, m_fpend, m_wrap, m_wr, m_clr;
    logic [15:0] m_lo;
    int          m_idx;
    logic [31:0] m_words;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic r, input logic en, input logic fl, input logic sv,
                        input logic [15:0] s, input logic wr);
        logic        acc_s, acc_w, pushed;
        logic [35:0] w;
        reset = r; enable = en; flush = fl; sample_valid = sv; sample = s; waitrequest = wr;
        if (r) begin
            exp_q.delete();
            m_half = 0; m_fpend = 0; m_wrap = 0; m_wr = 0; m_clr = 1;
            m_idx = 0; m_words = 0; m_lo = 0;
        end else begin
            acc_s  = sv && en && (exp_q.size() < DEPTH);
            acc_w  = m_wr && !wr;
            pushed = 0;
            w      = '0;
            if (acc_s && m_half) begin
                w = {s, m_lo, 4'b1111}; pushed = 1; m_half = 0; m_fpend = 0;
            end else if (acc_s) begin
                m_lo = s; m_half = 1; m_fpend = m_fpend || fl;
            end else if (fl || m_fpend) begin
                if (!m_half) m_fpend = 0;
                else if (exp_q.size() < DEPTH) begin
                    w = {16'h0, m_lo, 4'b0011}; pushed = 1; m_half = 0; m_fpend = 0;
                end else m_fpend = 1;
            end
            if (acc_w) begin
                void'(exp_q.pop_front());
                m_words++;
                m_wrap = (m_idx == NW - 1);
                m_idx  = (m_idx + 1) % NW;
            end else m_wrap = 0;
            if (pushed) exp_q.push_back(w);
            // A word is offered on the bus once it has sat in the queue for one edge.
            m_wr = (exp_q.size() - int'(pushed)) > 0;
            if (m_wr) m_clr = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("write", write, m_wr);
        chk("address", address, BASE + 23'(m_idx));
        chk("words_written", words_written, m_words);
        chk("wrapped", wrapped, m_wrap);
        chk("idle", idle, (exp_q.size() == 0) && !m_half && !m_fpend);
        chk("sample_ready", sample_ready, enable && (exp_q.size() < DEPTH));
        if (m_wr) begin
            chk("writedata", writedata, exp_q[0][35:4]);
            chk("byteenable", byteenable, exp_q[0][3:0]);
        end
        if (m_clr) begin
            chk("writedata_rst", writedata, 32'h0);
            chk("byteenable_rst", byteenable, 4'h0);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 16'h0, 0);
    endtask

    initial begin
        int acc;
        // reset with random inputs
        for (int i = 0; i < 3; i++)
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        step(0, 1, 0, 0, 16'h0, 0);
        // single pair
        step(0, 1, 0, 1, 16'h1111, 0);
        step(0, 1, 0, 1, 16'h2222, 0);
        idle_steps(4);
        // stall of several cycles during a write
        step(0, 1, 0, 1, 16'h3333, 1);
        step(0, 1, 0, 1, 16'h4444, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 16'h0, 1);
        idle_steps(4);
        // half-word flush
        step(0, 1, 0, 1, 16'hABCD, 0);
        step(0, 1, 1, 0, 16'h0, 0);
        idle_steps(4);
        // flush on the edge of the second sample
        step(0, 1, 0, 1, 16'h5555, 0);
        step(0, 1, 1, 1, 16'h6666, 0);
        idle_steps(5);
        // five back-to-back words through the wrap point
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 16'(16'h7000 + i), 0);
        idle_steps(5);
        // back-pressure: FIFO fills while the slave stalls
        acc = 0;
        for (int i = 0; i < 14; i++) begin
            if (sample_ready) acc++;
            step(0, 1, 0, 1, 16'(16'h8000 + i), 1);
        end
        chk("bp_accepted", 64'(acc), 64'd8);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 16'h0, 0);
        // reset in the middle of a stalled write
        step(0, 1, 0, 1, 16'h9001, 1);
        step(0, 1, 0, 1, 16'h9002, 1);
        step(0, 1, 0, 1, 16'h9003, 1);
        step(0, 1, 0, 0, 16'h0, 1);
        step(1, 1, 0, 1, 16'h9004, 1);
        idle_steps(4);
        // random traffic
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 16'($urandom), $urandom_range(0, 2) == 0);
        step(0, 1, 1, 0, 16'h0, 0);
        idle_steps(12);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/audio_sample_writer.md
# audio_sample_writer

Avalon-MM write master that takes a stream of 16-bit audio samples, packs two samples per 32-bit word, buffers the words in a small FIFO, and writes them to consecutive word addresses of a circular buffer in memory. It is the write-side counterpart of the sample reader on the audio path: the recording path feeds it, and the reader later plays the stored buffer back. It absorbs `waitrequest` stalls through the FIFO and applies back-pressure upstream only when the FIFO is full.

## Interface
- `ADDR_W`, 23, width of the Avalon word address.
- `BASE_ADDR`, 0, first word address of the circular buffer.
- `NUM_WORDS`, 1024, buffer length in 32-bit words; must be ≥2.
- `FIFO_DEPTH`, 4, word FIFO entries; power of 2, ≥2.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, no new samples are accepted; FIFO still drains.
- `flush` in 1: single-cycle pulse; forces out a pending half-filled word.
- `sample_valid` in 1: upstream sample present.
- `sample` in 16: audio sample.
- `sample_ready` out 1: equals `enable && !fifo_full`, combinational.
- `waitrequest` in 1: Avalon slave stall.
- `address` out ADDR_W: Avalon word address.
- `write` out 1: Avalon write strobe.
- `writedata` out 32: packed samples.
- `byteenable` out 4: `4'b1111` for a full word, `4'b0011` for a flushed half word.
- `wrapped` out 1: one-cycle pulse on the edge that accepts the write to `BASE_ADDR+NUM_WORDS-1`.
- `words_written` out 32: count of accepted writes; wraps modulo 2^32.
- `idle` out 1: FIFO empty, `write` low, no pending half, no pending flush.

## Operation
- **Accept:** a sample is accepted on an edge where `sample_valid && sample_ready` is true.
- **Packer:**
  - The first sample goes to `lo` and sets `half_pending`.
  - The second sample completes the word `{sample, lo}`, which is pushed to the FIFO with `be=1111` on the same edge; `half_pending` then clears.
- **Flush:**
  - A `flush` pulse sets `flush_pending`.
  - When `flush_pending` is set and `half_pending` is set, the packer pushes `{16'h0, lo}` with `be=0011` on the first edge the FIFO is not full, then clears both flags.
  - With no half pending, `flush_pending` simply clears.
- **Flush with a sample on the same edge:** the sample is applied first.
  - If that sample completes a pair, the full word is pushed and `flush_pending` clears with nothing else pushed.
  - If that sample is a new `lo`, the flush pushes it as a half word on the next eligible edge.
- **Write FSM** (states in package enum):
  - `IDLE`: if FIFO is non-empty, load the head into `writedata`/`byteenable`, set `write<=1`, go to `BUS`.
  - `BUS`: `write`, `address`, `writedata` and `byteenable` are held stable while `waitrequest=1`.
  - On the edge where `waitrequest=0`, the write is accepted:
    - pop the FIFO;
    - increment `words_written`;
    - advance `address` by 1; `BASE_ADDR+NUM_WORDS-1` wraps to `BASE_ADDR` and pulses `wrapped`;
    - if another entry is available after the pop, load it and stay in `BUS` with `write=1` (back-to-back);
    - otherwise clear `write` and go to `IDLE`.
- **Simultaneous push and pop:** allowed; the FIFO count is unchanged.
- **Push when full:** cannot occur, because `sample_ready` and the flush gate both block it.
- **Reset** (including mid-burst): FSM goes to `IDLE`; FIFO is emptied; `half_pending` and `flush_pending` clear; `address=BASE_ADDR`, `write=0`, `writedata=0`, `byteenable=0`, `wrapped=0`, `words_written=0`, `idle=1`. Any in-flight write is abandoned.

## Timing
- Pair completed on edge N: the word is in the FIFO after edge N, and `write=1` from edge N+1. With `waitrequest=0`, the write is accepted at edge N+2.
- Sustained throughput with `waitrequest=0`: one word per cycle. This is limited by input rate, so it is one word per two accepted samples.
- `sample_ready` drops combinationally in the cycle the FIFO is full and rises the cycle after a pop.
- `wrapped` is high for exactly one cycle, the cycle following the wrapping acceptance edge.
- `idle` is registered: it reflects state after the current edge.

## Structure
- Package `audio_mem_pkg`:
  - `wr_state_t` enum (`IDLE`, `BUS`);
  - constants `BE_FULL=4'b1111` and `BE_LOW=4'b0011`;
  - struct `word_entry_t` (`data[31:0]`, `be[3:0]`).
- Sub-module `sample_word_fifo`:
  - synchronous FIFO of `word_entry_t`, parameterised by `FIFO_DEPTH`;
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`;
  - same-cycle push/pop when full is legal.
- The packer, flush logic, write FSM and address counter live in the top module.

## Test plan
- **Reset:** hold `reset` 3 cycles with random inputs -> `write=0`, `address=BASE_ADDR`, `words_written=0`, `idle=1`, `sample_ready=enable`.
- **Single pair:** samples `0x1111` then `0x2222`, `waitrequest=0` -> one write, `address=BASE_ADDR`, `writedata=0x2222_1111`, `byteenable=1111`, `words_written=1`.
- **Stall:** `waitrequest=1` for 5 cycles during a write -> `address`, `writedata` and `byteenable` are stable for all 6 cycles, the write is accepted exactly once, and `words_written` increments by 1.
- **Flush:**
  - sample `0xABCD` then a `flush` pulse -> `writedata=0x0000_ABCD`, `byteenable=0011`.
  - `flush` on the same edge as a second sample -> only a full word is written.
- **Wrap:** `NUM_WORDS=4`, 5 words -> addresses `B, B+1, B+2, B+3, B`; `wrapped` pulses once, after the `B+3` acceptance.
- **Back-pressure:** `FIFO_DEPTH=4`, `waitrequest=1`, continuous valid samples -> `sample_ready` falls after 8 samples are accepted. After `waitrequest` is released, 4 consecutive writes complete with no loss or duplication, followed by the remaining packed data.
